multi_pulse_timer: RTL and testbench

//  Multi-channel pulse-width timer for echo/PWM inputs (e.g. ultrasonic range sensors).

---
 rtl/multi_pulse_timer.sv | 156 +++++++++++++++
 tb/tb_multi_pulse_timer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_timer.sv
// rtl/multi_pulse_timer.sv - multi-channel pulse-width timer with round-robin result stream
module multi_pulse_timer #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHW-1:0]      out_channel,
  output logic [WIDTH-1:0]    out_duration,
  output logic                out_timeout,
  output logic                out_overrun
);

  localparam logic [WIDTH-1:0] MAXC = {WIDTH{1'b1}};

  typedef enum logic [1:0] {WAIT_LOW, ARMED, MEASURE} state_t;

  logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]    s, p;
  logic [SYNC_STAGES-1:0] primed;
  logic                   sync_ok;

  assign s       = sync_q[SYNC_STAGES-1];
  assign sync_ok = primed[SYNC_STAGES-1];

  // primed keeps WAIT_LOW from trusting the reset value of the synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      p      <= '0;
      primed <= '0;
    end else begin
      sync_q[0] <= signal;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      p      <= s;
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
    end
  end

  state_t              state   [CHANNELS];
  logic [WIDTH-1:0]    cnt     [CHANNELS];
  logic [WIDTH-1:0]    cap_dur [CHANNELS];
  logic [CHANNELS-1:0] cap_vld, cap_to;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]   <= WAIT_LOW;
        cnt[i]     <= '0;
        cap_dur[i] <= '0;
      end
      cap_vld <= '0;
      cap_to  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cap_vld[i] <= 1'b0;
        case (state[i])
          WAIT_LOW: if (sync_ok && !s[i]) state[i] <= ARMED;
          ARMED: begin
            if (s[i] && !p[i]) begin
              state[i] <= MEASURE;
              cnt[i]   <= WIDTH'(1);
            end
          end
          MEASURE: begin
            if (!s[i] && p[i]) begin
              cap_vld[i] <= 1'b1;
              cap_dur[i] <= cnt[i];
              cap_to[i]  <= 1'b0;
              state[i]   <= ARMED;
            end else if (s[i] && cnt[i] == MAXC) begin
              cap_vld[i] <= 1'b1;
              cap_dur[i] <= MAXC;
              cap_to[i]  <= 1'b1;
              state[i]   <= WAIT_LOW;
            end else if (s[i]) begin
              cnt[i] <= cnt[i] + WIDTH'(1);
            end
          end
          default: state[i] <= WAIT_LOW;
        endcase
      end
    end
  end

  logic [WIDTH-1:0]    hdur [CHANNELS];
  logic [CHANNELS-1:0] pend, hov, hto, xfer;
  logic [CHW-1:0]      rr, sel_ch;
  logic [CHW:0]        cand;
  logic                sel_found, load_en, take;

  assign load_en = !out_valid || out_ready;
  assign take    = load_en && sel_found;

  // first pending channel at or after the round-robin pointer
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = {1'b0, rr} + (CHW+1)'(k);
      if (cand >= (CHW+1)'(CHANNELS)) cand = cand - (CHW+1)'(CHANNELS);
      if (!sel_found && pend[cand[CHW-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = cand[CHW-1:0];
      end
    end
  end

  always_comb begin
    xfer = '0;
    for (int i = 0; i < CHANNELS; i++) xfer[i] = take && (sel_ch == CHW'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) hdur[i] <= '0;
      pend         <= '0;
      hov          <= '0;
      hto          <= '0;
      rr           <= '0;
      out_valid    <= 1'b0;
      out_channel  <= '0;
      out_duration <= '0;
      out_timeout  <= 1'b0;
      out_overrun  <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cap_vld[i]) begin
          hdur[i] <= cap_dur[i];
          hto[i]  <= cap_to[i];
          hov[i]  <= pend[i] && !xfer[i];
          pend[i] <= 1'b1;
        end else if (xfer[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (load_en) begin
        out_valid <= sel_found;
        if (sel_found) begin
          out_channel  <= sel_ch;
          out_duration <= hdur[sel_ch];
          out_timeout  <= hto[sel_ch];
          out_overrun  <= hov[sel_ch];
          rr           <= (sel_ch == CHW'(CHANNELS-1)) ? '0 : sel_ch + CHW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_pulse_timer.sv
// tb/tb_multi_pulse_timer.sv - scoreboard bench for multi_pulse_timer
module tb_multi_pulse_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sig = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [1:0]  out_channel;
  logic [15:0] out_duration;
  logic        out_timeout, out_overrun;

  logic [3:0]  sig4 = '0;
  logic        v4, to4, ov4;
  logic [1:0]  ch4;
  logic [3:0]  dur4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int ch;
    int dur;
    int to;
    int ov;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];

  multi_pulse_timer #(.CHANNELS(4), .WIDTH(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .signal(sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_duration(out_duration), .out_timeout(out_timeout), .out_overrun(out_overrun)
  );

  multi_pulse_timer #(.CHANNELS(4), .WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .reset(reset), .signal(sig4),
    .out_valid(v4), .out_ready(1'b1), .out_channel(ch4),
    .out_duration(dur4), .out_timeout(to4), .out_overrun(ov4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int dur, input int to, input int ov);
    exp_t e;
    e.ch = ch; e.dur = dur; e.to = to; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic pulse(input int ch, input int n);
    sig[ch] = 1'b1;
    repeat (n) tick();
    sig[ch] = 1'b0;
    push(ch, n, 0, 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || sb4.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, sb.size() + sb4.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
  endtask

  always @(negedge clk) begin
    int idx;
    if (!reset && out_valid && out_ready) begin
      idx = -1;
      for (int k = 0; k < sb.size(); k++)
        if (idx < 0 && sb[k].ch == int'(out_channel)) idx = k;
      chk("word_expected", idx >= 0, 1);
      if (idx >= 0) begin
        chk("duration", out_duration, sb[idx].dur);
        chk("timeout", out_timeout, sb[idx].to);
        chk("overrun", out_overrun, sb[idx].ov);
        sb.delete(idx);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && v4) begin
      chk("w4_word_expected", sb4.size() != 0, 1);
      if (sb4.size() != 0) begin
        chk("w4_channel", ch4, sb4[0].ch);
        chk("w4_duration", dur4, sb4[0].dur);
        chk("w4_timeout", to4, sb4[0].to);
        chk("w4_overrun", ov4, sb4[0].ov);
        void'(sb4.pop_front());
      end
    end
  end

  initial begin
    int lat;
    int hi_left [4];
    int lo_left [4];
    int len [4];
    exp_t e;

    // 1: reset state, single ch0 pulse, latency
    reset = 1'b1;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_channel", out_channel, 0);
    chk("rst_duration", out_duration, 0);
    chk("rst_timeout", out_timeout, 0);
    chk("rst_overrun", out_overrun, 0);
    reset = 1'b0;
    repeat (5) tick();
    pulse(0, 10);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, 5);
    drain("t1_drain", 50);
    repeat (20) tick();
    chk("t1_idle_valid", out_valid, 0);

    // 2: reset during ch1 pulse, released with ch1 still high
    do_reset();
    sig[1] = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t2_valid_in_reset", out_valid, 0);
    reset = 1'b0;
    repeat (10) tick();
    sig[1] = 1'b0;
    repeat (15) tick();
    chk("t2_no_partial", out_valid, 0);
    chk("t2_sb_empty", sb.size(), 0);
    pulse(1, 8);
    drain("t2_drain", 50);

    // 3: WIDTH=4 instance saturates at 15
    do_reset();
    e.ch = 2; e.dur = 15; e.to = 1; e.ov = 0;
    sb4.push_back(e);
    sig4[2] = 1'b1;
    repeat (40) tick();
    sig4[2] = 1'b0;
    repeat (20) tick();
    chk("t3_one_word", sb4.size(), 0);
    e.dur = 5; e.to = 0;
    sb4.push_back(e);
    sig4[2] = 1'b1;
    repeat (5) tick();
    sig4[2] = 1'b0;
    drain("t3_drain", 50);

    // 4: stalled output, ch0 overwritten while held
    do_reset();
    out_ready = 1'b0;
    pulse(1, 4);
    repeat (8) tick();
    sig[0] = 1'b1;
    repeat (5) tick();
    sig[0] = 1'b0;
    repeat (8) tick();
    sig[0] = 1'b1;
    repeat (7) tick();
    sig[0] = 1'b0;
    push(0, 7, 0, 1);
    repeat (8) tick();
    chk("t4_stall_valid", out_valid, 1);
    chk("t4_stall_ch", out_channel, 1);
    chk("t4_stall_dur", out_duration, 4);
    repeat (3) tick();
    chk("t4_hold_valid", out_valid, 1);
    chk("t4_hold_ch", out_channel, 1);
    chk("t4_hold_dur", out_duration, 4);
    out_ready = 1'b1;
    drain("t4_drain", 50);

    // 5: simultaneous falls drain in round-robin order
    do_reset();
    sig[3] = 1'b1; tick();
    sig[2] = 1'b1; tick();
    sig[1] = 1'b1; tick();
    sig[0] = 1'b1; tick(); tick(); tick();
    sig = '0;
    push(0, 3, 0, 0);
    push(1, 4, 0, 0);
    push(2, 5, 0, 0);
    push(3, 6, 0, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("t5_valid", out_valid, 1);
      chk("t5_channel", out_channel, k);
      tick();
    end
    drain("t5_drain", 50);

    // 6: one-cycle pulse, then random pulses on all channels
    pulse(3, 1);
    drain("t6_drain", 50);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      hi_left[c] = 0;
      len[c] = 0;
      lo_left[c] = $urandom_range(20, 8);
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (hi_left[c] > 0) begin
          hi_left[c]--;
          if (hi_left[c] == 0) begin
            sig[c] = 1'b0;
            push(c, len[c], 0, 0);
            lo_left[c] = $urandom_range(20, 8);
          end
        end else if (lo_left[c] > 0) begin
          lo_left[c]--;
          if (lo_left[c] == 0 && cyc < 9900) begin
            len[c] = $urandom_range(40, 1);
            hi_left[c] = len[c];
            sig[c] = 1'b1;
          end
        end
      end
      tick();
    end
    drain("rand_drain", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
